// File: rtl/csa_pkg.sv
// Shared types for the carry-save accumulator slice.
//   CSA_W        : carry-save datapath width
//   csa_word_t   : one datapath word
//   acc_state_t  : accumulator sequencer states
package csa_pkg;

   localparam int unsigned CSA_W = 18;

   typedef logic [CSA_W-1:0] csa_word_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACC     = 2'd1,
      RESOLVE = 2'd2,
      OUT     = 2'd3
   } acc_state_t;

endpackage : csa_pkg

// File: rtl/csa_18b.sv
// 18-bit 3:2 carry-save adder, purely combinational.
//   a_i, b_i, c_i : three addends
//   sum_o         : bitwise sum, weight 2^i
//   carry_o       : bitwise carry, weight 2^(i+1) (caller shifts it on reuse)
module csa_18b
   import csa_pkg::*;
(
   input  csa_word_t a_i,
   input  csa_word_t b_i,
   input  csa_word_t c_i,
   output csa_word_t sum_o,
   output csa_word_t carry_o
);

   assign sum_o   = a_i ^ b_i ^ c_i;
   assign carry_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule : csa_18b

// File: rtl/csa_acc_ctrl.sv
// Burst accumulator: sums LEN operands in redundant sum/carry form through one
// csa_18b, resolves the pair with a single add, then holds the result until taken.
//   clk, rst_n           : clock, async active-low reset
//   start, len           : begin a burst of len operands (sampled in IDLE only)
//   in_valid/in_ready    : operand handshake, in_data is the operand
//   out_valid/out_ready  : result handshake, out_data is the sum mod 2**WIDTH
//   busy                 : high whenever not IDLE
module csa_acc_ctrl
   import csa_pkg::*;
#(
   parameter int unsigned WIDTH = CSA_W,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
);

   acc_state_t       state_q, state_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic [WIDTH-1:0] c_q, c_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             in_ready_q, out_valid_q, busy_q;

   logic [WIDTH-1:0] c_shift;
   logic [WIDTH-1:0] csa_sum, csa_carry;

   // Carry bit i has weight 2^(i+1); the shift drops the MSB carry so the sum wraps.
   assign c_shift = c_q << 1;

   csa_18b u_csa (
      .a_i     (s_q),
      .b_i     (c_shift),
      .c_i     (in_data),
      .sum_o   (csa_sum),
      .carry_o (csa_carry)
   );

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      c_d     = c_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               s_d     = '0;
               c_d     = '0;
               cnt_d   = len;
               // A zero-length burst resolves the cleared pair, giving 0.
               state_d = (len != '0) ? ACC : RESOLVE;
            end
         end
         ACC: begin
            if (in_valid) begin
               s_d   = csa_sum;
               c_d   = csa_carry;
               cnt_d = CNT_W'(cnt_q - 1'b1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = RESOLVE;
               end
            end
         end
         RESOLVE: begin
            res_d   = s_q + c_shift;
            state_d = OUT;
         end
         OUT: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, datapath and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         s_q         <= '0;
         c_q         <= '0;
         res_q       <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         s_q         <= s_d;
         c_q         <= c_d;
         res_q       <= res_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= (state_d == ACC);
         out_valid_q <= (state_d == OUT);
         busy_q      <= (state_d != IDLE);
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign out_data  = res_q;

endmodule : csa_acc_ctrl
